// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and helpers for the pipeline stage register
package pipe_stage_reg_pkg;

  localparam int OCC_W          = 2;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CNT_W  = 16;

  function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating event counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage with optional skid entry, stall, flush and counters
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q;
  logic              main_valid_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic              skid_valid_q;
  logic              accept;
  logic              emit;

  assign out_valid = main_valid_q && !stall;
  assign out_data  = main_data_q;

  // Flush swallows both handshakes of its cycle so nothing is taken in or retired.
  assign accept = in_valid && in_ready && !flush;
  assign emit   = out_valid && out_ready && !flush;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid_d;
      logic [DATA_W-1:0] skid_data_q;
      logic [DATA_W-1:0] skid_data_d;

      // Ready comes from registered state only, breaking the out_ready -> in_ready path.
      assign in_ready = rstn && !stall && !skid_valid_q;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
          main_data_d  = '0;
          skid_valid_d = 1'b0;
          skid_data_d  = '0;
        end else if (emit && skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (emit) begin
          main_valid_d = accept;
          if (accept) begin
            main_data_d = in_data;
          end
        end else if (accept) begin
          if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          skid_valid_q <= 1'b0;
          skid_data_q  <= '0;
        end else if (!stall) begin
          skid_valid_q <= skid_valid_d;
          skid_data_q  <= skid_data_d;
        end
      end
    end else begin : g_noskid
      assign skid_valid_q = 1'b0;
      assign in_ready     = rstn && !stall && (!main_valid_q || out_ready);

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
          main_data_d  = '0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else if (emit) begin
          main_valid_d = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
    end else if (!stall) begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end

  assign occupancy = occ_count(main_valid_q, skid_valid_q);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (stall),
    .cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (out_ready && !out_valid),
    .cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;
  logic [3:0]  bubble_cnt;

  logic        in_valid0;
  logic        in_ready0;
  logic [31:0] in_data0;
  logic        out_valid0;
  logic        out_ready0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;
  logic [15:0] stall_cnt0;
  logic [15:0] bubble_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut0 (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid0),
    .in_ready   (in_ready0),
    .in_data    (in_data0),
    .out_valid  (out_valid0),
    .out_ready  (out_ready0),
    .out_data   (out_data0),
    .occupancy  (occupancy0),
    .stall_cnt  (stall_cnt0),
    .bubble_cnt (bubble_cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; stall = 0; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    in_valid0 = 0; in_data0 = 0; out_ready0 = 0;
    #2 rstn = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt); end
    tick();
    rstn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_bubble_saturation();
    out_ready = 1'b1;
    repeat (5) tick();
    checks++; if (bubble_cnt !== 4'd5) begin errors++; $display("FAIL bubble_cnt_5: got %0d expected 5", bubble_cnt); end
    repeat (15) tick();
    checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL bubble_cnt_sat: got %0d expected 15", bubble_cnt); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt_idle: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_word[%0d]: got v=%0b d=%0h occ=%0d expected v=1 d=%0h occ=1", i, out_valid, out_data, occupancy, i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %0b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%0b expected occ=2 rdy=0", occupancy, in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin errors++; $display("FAIL bp_first: got v=%0b d=%0h expected v=1 d=a", out_valid, out_data); end
    tick();
    checks++; if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second: got d=%0h occ=%0d rdy=%0b expected d=b occ=1 rdy=1", out_data, occupancy, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_flush();
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    stall = 1'b1; flush = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_outputs: got v=%0b rdy=%0b expected 0/0", out_valid, in_ready); end
    repeat (3) tick();
    checks++; if (occupancy !== 2'd1 || out_data !== 32'h55) begin errors++; $display("FAIL stall_hold: got occ=%0d d=%0h expected occ=1 d=55", occupancy, out_data); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    stall = 1'b0;
    tick();
    flush = 1'b0;
    checks++; if (occupancy !== 2'd0 || out_data !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got occ=%0d d=%0h v=%0b expected 0/0/0", occupancy, out_data, out_valid); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL flush_keeps_cnt: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_flush_input();
    out_ready = 1'b1;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL flush_drop[%0d]: got v=%0b d=%0h occ=%0d expected v=0 occ=0", i, out_valid, out_data, occupancy);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL mid_pre_occ: got %0d expected 2", occupancy); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL mid_async_reset: got v=%0b occ=%0d rdy=%0b d=%0h expected 0/0/0/0", out_valid, occupancy, in_ready, out_data);
    end
    checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt); end
    tick();
    rstn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %0b expected 1", in_ready); end
    in_valid = 1'b1; in_data = 32'h99;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h99) begin errors++; $display("FAIL mid_first_word: got v=%0b d=%0h expected v=1 d=99", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL mid_drain: got v=%0b occ=%0d expected 0/0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_noskid();
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 32'hC1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL noskid_ready_empty: got %0b expected 1", in_ready0); end
    tick();
    in_valid0 = 1'b0;
    checks++; if (out_valid0 !== 1'b1 || occupancy0 !== 2'd1 || in_ready0 !== 1'b0) begin
      errors++; $display("FAIL noskid_full: got v=%0b occ=%0d rdy=%0b expected 1/1/0", out_valid0, occupancy0, in_ready0);
    end
    out_ready0 = 1'b1;
    in_valid0 = 1'b1; in_data0 = 32'hC2;
    #1;
    checks++; if (in_ready0 !== 1'b1 || out_data0 !== 32'hC1) begin errors++; $display("FAIL noskid_passthru_ready: got rdy=%0b d=%0h expected 1/c1", in_ready0, out_data0); end
    tick();
    in_valid0 = 1'b0;
    checks++; if (out_data0 !== 32'hC2 || occupancy0 !== 2'd1 || out_valid0 !== 1'b1) begin
      errors++; $display("FAIL noskid_swap: got d=%0h occ=%0d v=%0b expected c2/1/1", out_data0, occupancy0, out_valid0);
    end
    tick();
    checks++; if (occupancy0 !== 2'd0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL noskid_drain: got occ=%0d v=%0b expected 0/0", occupancy0, out_valid0); end
    out_ready0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bubble_saturation();
    test_stream();
    test_backpressure();
    test_stall_flush();
    test_flush_input();
    test_reset_midstream();
    test_noskid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
